// File: rtl/bus_gate_arbiter_if.sv
// Bus-gate arbitration interface: requests/locks in, one-hot gate select and status out.
//   req[3:0]            request per source ([3]=PC, [2]=MDR, [1]=MARMUX, [0]=ALU)
//   lock[3:0]           per-source lock, honoured only for the current owner
//   gate[3:0]           registered one-hot bus select (0 = idle)
//   grant_valid         high when gate is non-zero
//   grant_id[1:0]       index of current (or last) owner
//   contention_cnt[7:0] saturating count of multi-request cycles
// modport master: requester side; modport slave: arbiter side.
interface bus_gate_arbiter_if;
  logic [3:0] req;
  logic [3:0] lock;
  logic [3:0] gate;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [7:0] contention_cnt;

  modport master (
    output req, lock,
    input  gate, grant_valid, grant_id, contention_cnt
  );

  modport slave (
    input  req, lock,
    output gate, grant_valid, grant_id, contention_cnt
  );
endinterface

// File: rtl/bus_gate_arbiter.sv
// Round-robin arbiter owning the one-hot gate select of the shared 16-bit CPU bus.
// Sources: 3=PC, 2=MDR, 1=MARMUX, 0=ALU. An unlocked owner is preempted after
// HOLD_MAX grant cycles when another source is waiting.
// Ports:
//   Clk    rising-edge clock
//   Reset  synchronous active-low reset
//   bus    bus_gate_arbiter_if.slave (req, lock in; gate, grant_valid,
//          grant_id, contention_cnt out, all registered)
// Parameter: HOLD_MAX (1..15, default 4).
// Build option: define BUS_TURNAROUND_EN to insert one dead bus cycle (TURN)
// on every change of owner.
module bus_gate_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  bus_gate_arbiter_if.slave  bus
);

  localparam int unsigned NSRC = 4;
  localparam int unsigned IW   = 2;
  localparam int unsigned HW   = 4;
  localparam int unsigned CCW  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifdef BUS_TURNAROUND_EN
    S_TURN  = 2'd2,
`endif
    S_GRANT = 2'd1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [HW-1:0]   hold_q, hold_d, hold_inc;
  logic [NSRC-1:0] others;
  logic [NSRC-1:0] gate_d;
  logic [CCW-1:0]  cont_d;
  logic            handover;

  function automatic logic [NSRC-1:0] onehot(input logic [IW-1:0] idx);
    logic [NSRC-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // First set bit of m searching from (from-1) downward with wrap; lower i wins.
  function automatic logic [IW-1:0] pick(input logic [NSRC-1:0] m,
                                         input logic [IW-1:0]   from);
    logic [IW-1:0] idx;
    logic [IW-1:0] sel;
    sel = from;
    for (int i = NSRC; i >= 1; i--) begin
      idx = from - IW'(i);
      if (m[idx]) sel = idx;
    end
    return sel;
  endfunction

  // Next-state, pointer, hold counter and registered-output values.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    hold_d   = hold_q;
    handover = 1'b0;
    others   = bus.req & ~onehot(last_q);
    hold_inc = (hold_q >= HW'(HOLD_MAX)) ? HW'(HOLD_MAX) : hold_q + HW'(1);

    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          last_d  = pick(bus.req, last_q);
          state_d = S_GRANT;
          hold_d  = '0;
        end
      end
      S_GRANT: begin
        if (bus.req[last_q]) begin
          if (bus.lock[last_q]) begin
            hold_d = '0;
          end else begin
            hold_d = hold_inc;
            // hold_inc counts the grant cycle now ending
            if ((hold_inc == HW'(HOLD_MAX)) && (|others)) handover = 1'b1;
          end
        end else if (|others) begin
          handover = 1'b1;
        end else begin
          state_d = S_IDLE;
          hold_d  = '0;
        end
      end
`ifdef BUS_TURNAROUND_EN
      S_TURN: begin
        hold_d = '0;
        if (|bus.req) begin
          last_d  = pick(bus.req, last_q);
          state_d = S_GRANT;
        end else begin
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        hold_d  = '0;
      end
    endcase

    if (handover) begin
      hold_d = '0;
`ifdef BUS_TURNAROUND_EN
      state_d = S_TURN;
`else
      last_d = pick(others, last_q);
`endif
    end

    gate_d = (state_d == S_GRANT) ? onehot(last_d) : '0;
    cont_d = bus.contention_cnt;
    if (($countones(bus.req) >= 2) && (bus.contention_cnt != '1))
      cont_d = bus.contention_cnt + CCW'(1);
  end

  // State and output registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q            <= S_IDLE;
      last_q             <= '0;
      hold_q             <= '0;
      bus.gate           <= '0;
      bus.grant_valid    <= 1'b0;
      bus.grant_id       <= '0;
      bus.contention_cnt <= '0;
    end else begin
      state_q            <= state_d;
      last_q             <= last_d;
      hold_q             <= hold_d;
      bus.gate           <= gate_d;
      bus.grant_valid    <= |gate_d;
      bus.grant_id       <= last_d;
      bus.contention_cnt <= cont_d;
    end
  end

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Self-checking bench for bus_gate_arbiter: a hand-derived vector table, a
// turnaround sequence (when BUS_TURNAROUND_EN is defined), randomized traffic
// against a reference model for HOLD_MAX=4 and HOLD_MAX=1 instances, and a
// contention-counter saturation run.
module tb_bus_gate_arbiter;

`ifdef BUS_TURNAROUND_EN
  localparam bit TA = 1'b1;
`else
  localparam bit TA = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  bus_gate_arbiter_if bus0 ();
  bus_gate_arbiter_if bus1 ();

  assign bus1.req  = bus0.req;
  assign bus1.lock = bus0.lock;

  bus_gate_arbiter #(.HOLD_MAX(4)) dut0 (.Clk(clk), .Reset(reset), .bus(bus0));
  bus_gate_arbiter #(.HOLD_MAX(1)) dut1 (.Clk(clk), .Reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner index (-1 = bus idle), round-robin pointer,
  // cycles held, pending turnaround flag; contention shared by both instances.
  int m_owner [2];
  int m_last  [2];
  int m_held  [2];
  bit m_turn  [2];
  int m_cont;
  int m_hold  [2] = '{4, 1};

  function automatic int rr(input logic [3:0] mask, input int from);
    int i;
    for (int k = 1; k <= 4; k++) begin
      i = (from - k + 8) % 4;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input int d, input logic r, input logic [3:0] rq,
                            input logic [3:0] lk);
    int o;
    logic [3:0] oth;
    bit sw;
    if (!r) begin
      m_owner[d] = -1; m_last[d] = 0; m_held[d] = 0; m_turn[d] = 0;
      return;
    end
    if (m_turn[d]) begin
      m_turn[d] = 0;
      o = rr(rq, m_last[d]);
      m_owner[d] = o;
      if (o >= 0) begin m_last[d] = o; m_held[d] = 0; end
    end else if (m_owner[d] < 0) begin
      o = rr(rq, m_last[d]);
      if (o >= 0) begin m_owner[d] = o; m_last[d] = o; m_held[d] = 0; end
    end else begin
      oth = rq & ~(4'b0001 << m_owner[d]);
      sw  = 0;
      if (rq[m_owner[d]]) begin
        if (lk[m_owner[d]]) m_held[d] = 0;
        else begin
          m_held[d]++;
          sw = (m_held[d] >= m_hold[d]) && (oth != 0);
        end
      end else if (oth != 0) begin
        sw = 1;
      end else begin
        m_owner[d] = -1;
      end
      if (sw) begin
        m_held[d] = 0;
        if (TA) begin
          m_turn[d]  = 1;
          m_owner[d] = -1;
        end else begin
          o = rr(oth, m_owner[d]);
          m_owner[d] = o;
          m_last[d]  = o;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    logic [3:0] eg;
    for (int d = 0; d < 2; d++) begin
      eg = (m_owner[d] < 0) ? 4'b0000 : 4'(4'b0001 << m_owner[d]);
      if (d == 0) begin
        chk("dut0.gate", 32'(bus0.gate), 32'(eg));
        chk("dut0.grant_valid", 32'(bus0.grant_valid), 32'(eg != 0));
        chk("dut0.grant_id", 32'(bus0.grant_id), 32'(m_last[d]));
        chk("dut0.contention_cnt", 32'(bus0.contention_cnt), 32'(m_cont));
      end else begin
        chk("dut1.gate", 32'(bus1.gate), 32'(eg));
        chk("dut1.grant_valid", 32'(bus1.grant_valid), 32'(eg != 0));
        chk("dut1.grant_id", 32'(bus1.grant_id), 32'(m_last[d]));
        chk("dut1.contention_cnt", 32'(bus1.contention_cnt), 32'(m_cont));
      end
    end
  endtask

  // One clock: drive at negedge, step model at posedge, compare 1 time unit later.
  task automatic cycle(input logic r, input logic [3:0] rq, input logic [3:0] lk);
    @(negedge clk);
    reset     = r;
    bus0.req  = rq;
    bus0.lock = lk;
    @(posedge clk);
    if (!r) m_cont = 0;
    else if ($countones(rq) >= 2 && m_cont < 255) m_cont++;
    model_step(0, r, rq, lk);
    model_step(1, r, rq, lk);
    #1;
    check_models();
  endtask

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] gate;
    logic [1:0] id;
    logic [7:0] cnt;
  } vec_t;

  vec_t vt [20];

  initial begin
    logic [3:0] rq;
    logic [3:0] lk;
    logic       r;
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    bus0.req  = '0;
    bus0.lock = '0;
    m_cont    = 0;
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_last[d] = 0; m_held[d] = 0; m_turn[d] = 0;
    end

`ifndef BUS_TURNAROUND_EN
    // Expected values for the HOLD_MAX=4 instance, derived by hand.
    vt[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 8'd0};
    vt[1]  = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 2'd3, 8'd1};
    vt[2]  = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 2'd3, 8'd2};
    vt[3]  = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 2'd3, 8'd3};
    vt[4]  = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 2'd3, 8'd4};
    vt[5]  = '{1'b1, 4'b1111, 4'b0000, 4'b0100, 2'd2, 8'd5};
    vt[6]  = '{1'b1, 4'b1111, 4'b0000, 4'b0100, 2'd2, 8'd6};
    vt[7]  = '{1'b1, 4'b1111, 4'b0000, 4'b0100, 2'd2, 8'd7};
    vt[8]  = '{1'b1, 4'b1111, 4'b0000, 4'b0100, 2'd2, 8'd8};
    vt[9]  = '{1'b1, 4'b1111, 4'b0000, 4'b0010, 2'd1, 8'd9};
    vt[10] = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 8'd9};
    vt[11] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd1, 8'd9};
    vt[12] = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 8'd9};
    vt[13] = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 8'd9};
    vt[14] = '{1'b1, 4'b0101, 4'b0100, 4'b0100, 2'd2, 8'd10};
    vt[15] = '{1'b1, 4'b0101, 4'b0100, 4'b0100, 2'd2, 8'd11};
    vt[16] = '{1'b1, 4'b0001, 4'b0100, 4'b0001, 2'd0, 8'd11};
    vt[17] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 2'd0, 8'd0};
    vt[18] = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 2'd3, 8'd1};
    vt[19] = '{1'b1, 4'b1001, 4'b0001, 4'b1000, 2'd3, 8'd2};
    for (int i = 0; i < 20; i++) begin
      cycle(vt[i].rst_n, vt[i].req, vt[i].lock);
      chk($sformatf("vec%0d.gate", i), 32'(bus0.gate), 32'(vt[i].gate));
      chk($sformatf("vec%0d.grant_id", i), 32'(bus0.grant_id), 32'(vt[i].id));
      chk($sformatf("vec%0d.contention_cnt", i), 32'(bus0.contention_cnt), 32'(vt[i].cnt));
    end
    // Locked MDR holds against a waiting ALU for 20 cycles.
    cycle(1'b1, 4'b0100, 4'b0000);
    for (int i = 0; i < 20; i++) cycle(1'b1, 4'b0101, 4'b0100);
    chk("lock.hold.gate", 32'(bus0.gate), 32'h4);
    cycle(1'b1, 4'b0001, 4'b0000);
    chk("lock.release.gate", 32'(bus0.gate), 32'h1);
`else
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b1, 4'b1000, 4'b0000);
    chk("turn.owner.gate", 32'(bus0.gate), 32'h8);
    cycle(1'b1, 4'b0001, 4'b0000);
    chk("turn.dead.gate", 32'(bus0.gate), 32'h0);
    chk("turn.dead.valid", 32'(bus0.grant_valid), 32'h0);
    cycle(1'b1, 4'b0001, 4'b0000);
    chk("turn.next.gate", 32'(bus0.gate), 32'h1);
`endif

    // Reset in the middle of an ALU grant, then PC first.
    cycle(1'b1, 4'b0001, 4'b0000);
    cycle(1'b0, 4'b0001, 4'b0000);
    chk("midreset.gate", 32'(bus0.gate), 32'h0);
    chk("midreset.grant_id", 32'(bus0.grant_id), 32'h0);
    cycle(1'b1, 4'b1111, 4'b0000);
    chk("postreset.gate", 32'(bus0.gate), 32'h8);

    // Randomized traffic; requests tend to persist to exercise hold/preempt.
    rq = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 3) rq = 4'($urandom);
      lk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      r  = ($urandom_range(0, 63) != 0);
      cycle(r, rq, lk);
    end

    // Contention counter saturation.
    cycle(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 300; i++) cycle(1'b1, 4'b1111, 4'b0000);
    chk("sat.contention_cnt", 32'(bus0.contention_cnt), 32'd255);
    chk("sat.contention_cnt.h1", 32'(bus1.contention_cnt), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_gate_arbiter.md
# bus_gate_arbiter

Registered arbiter that owns the one-hot gate select of the shared 16-bit CPU bus. It shares the bus between four sources: PC, MDR, MARMUX and ALU. Requesters assert a request and the block grants exactly one source, or none, per cycle using round-robin priority with a bounded hold time. Its `gate` output connects directly to the bus mux select, which decodes 4'b1000=PC, 4'b0100=MDR, 4'b0010=MARMUX and 4'b0001=ALU.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive grant cycles for an unlocked owner while another source is waiting. Legal range is 1..15.
- `Clk` in 1: rising-edge clock.
- `Reset` in 1: synchronous, active-low reset.
- `req` in 4: bus requests. [3]=PC, [2]=MDR, [1]=MARMUX, [0]=ALU.
- `lock` in 4: per-source lock. Only meaningful for the current owner; it suppresses `HOLD_MAX` preemption.
- `gate` out 4: registered one-hot bus select, or 4'b0000 when the bus is idle.
- `grant_valid` out 1: high exactly when `gate` is non-zero.
- `grant_id` out 2: encoded index of the current owner. Holds the last owner while idle.
- `contention_cnt` out 8: saturating count of cycles in which two or more `req` bits were high.

## Operation
- States:
  - IDLE: `gate`=0.
  - GRANT: `gate`=onehot(owner).
  - TURN: dead cycle with `gate`=0. Exists only when `BUS_TURNAROUND_EN` is defined.
- Round-robin pointer `last` holds the most recent owner index. The search order starts at (`last`-1) mod 4 and descends with wrap-around. Example: `last`=2 gives search order 1,0,3,2.
- IDLE: if any `req` bit is high, pick the first set bit in search order and go to GRANT. `last` becomes that index.
- GRANT, owner's `req` still high:
  - `lock[owner]`=1: stay in GRANT. Hold counter is frozen at 0.
  - Otherwise the hold counter increments each GRANT cycle, saturating at `HOLD_MAX`.
  - Counter equals `HOLD_MAX` and another `req` bit is high: preempt. The next owner comes from search order excluding the current owner.
  - Counter equals `HOLD_MAX` and no other requester: remain in GRANT.
- GRANT, owner's `req` low: release.
  - If another request is pending, grant it on the same edge (or go to TURN, see Configuration).
  - If none is pending, go to IDLE.
- The hold counter clears on every owner change and on entry to GRANT.
- `contention_cnt` increments on any cycle where popcount(`req`) ≥ 2, in every state. It saturates at 255 and never wraps.
- Reset values:
  - `gate`=0, `grant_valid`=0, `grant_id`=0, `contention_cnt`=0.
  - `last`=0, so PC has first priority after reset.
  - State is IDLE and the hold counter is 0.

## Timing
- All outputs are registered. There is no combinational path from `req` or `lock` to `gate`.
- Request-to-gate latency is 1 cycle from IDLE: `req` is sampled at edge N and `gate` is valid after edge N.
- Release latency: owner drops `req` before edge N, and `gate` changes after edge N.
- Handover with no turnaround: the old owner's bit falls and the new owner's bit rises on the same edge. `gate` is never multi-hot.
- An owner dropping `req` on the same cycle another source raises `req` is a normal handover to that source.
- All `req` bits dropping simultaneously sends the block to IDLE at the next edge.
- `lock` on a non-owner is ignored. `lock` without `req` does not hold the bus.
- Reset asserted mid-GRANT: at the next edge `gate`=0, state is IDLE, the counter is cleared and `last` is reset. Requests are re-arbitrated starting from the edge after Reset is deasserted.
- `HOLD_MAX`=1: with a waiting competitor, an unlocked owner holds for exactly 1 cycle.

## Configuration
- `BUS_TURNAROUND_EN` defined:
  - Every change of owner passes through TURN for one cycle with `gate`=0 and `grant_valid`=0.
  - In TURN the next owner is re-selected from the current `req` using the updated `last`. If no request remains, go to IDLE.
  - Handover therefore costs 1 idle bus cycle.
- `BUS_TURNAROUND_EN` undefined:
  - The TURN state does not exist and handover happens on a single edge.

## Test plan
- Reset, then `req`=4'b1111 held: `gate` goes 1000 (PC) first. Preemption then follows every 4 cycles (`HOLD_MAX`=4) in order 1000→0100→0010→0001→1000. `contention_cnt` increments every cycle.
- `req`=4'b0010 alone for 10 cycles: `gate`=0010 from cycle 1 through 10 with no preemption. `gate`=0 one cycle after `req` drops. `contention_cnt` stays 0.
- MDR owns with `lock`=4'b0100 while ALU requests for 20 cycles: `gate` stays 0100. ALU is granted 1 cycle after MDR drops `req`.
- With `BUS_TURNAROUND_EN`, PC releases while ALU requests: `gate` goes 1000→0000→0001, with exactly one zero cycle.
- Reset pulsed low during a GRANT to ALU: `gate`=0 and `grant_id`=0 after the edge. With `req`=1111 afterwards, PC is granted first.
- Hold `req`=1111 for 300 cycles: `contention_cnt` saturates at 255.
